// File: rtl/regfile_multiport_if.sv
// ---------------------------------------------------------------------------
// regfile_multiport_if
//   Bundles the register-file access signals between the decode/writeback
//   side (master) and the register file (slave).
//
//   Signals:
//     ready        slave->master  array cleared, writes accepted
//     wr_en        master->slave  per-port write enable        [NWR]
//     wr_addr      master->slave  write addresses              [NWR][AW]
//     wr_data      master->slave  write data                   [NWR][XLEN]
//     rd_addr      master->slave  read addresses               [NRD][AW]
//     rd_data      slave->master  read data (combinational)    [NRD][XLEN]
//     rd_busy      slave->master  scoreboard bit of rd_addr    [NRD]
//     sb_set_en    master->slave  mark sb_set_addr pending
//     sb_set_addr  master->slave  destination of issuing instruction
// ---------------------------------------------------------------------------
interface regfile_multiport_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
);
  localparam int AW = $clog2(NREGS);

  logic                           ready;
  logic [NWR-1:0]                 wr_en;
  logic [NWR-1:0][AW-1:0]         wr_addr;
  logic [NWR-1:0][XLEN-1:0]       wr_data;
  logic [NRD-1:0][AW-1:0]         rd_addr;
  logic [NRD-1:0][XLEN-1:0]       rd_data;
  logic [NRD-1:0]                 rd_busy;
  logic                           sb_set_en;
  logic [AW-1:0]                  sb_set_addr;

  modport master (
    input  ready, rd_data, rd_busy,
    output wr_en, wr_addr, wr_data, rd_addr, sb_set_en, sb_set_addr
  );

  modport slave (
    output ready, rd_data, rd_busy,
    input  wr_en, wr_addr, wr_data, rd_addr, sb_set_en, sb_set_addr
  );
endinterface

// File: rtl/regfile_multiport.sv
// ---------------------------------------------------------------------------
// regfile_multiport
//   NRD-read / NWR-write integer register file with a pending-write
//   scoreboard and a post-reset clear engine. Register 0 reads as zero and
//   ignores writes; the scoreboard bit of register 0 is always 0.
//
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high; restarts the clear sweep
//     bus    regfile_multiport_if.slave (see interface for signal list)
//
//   Behaviour:
//     CLEAR: one register zeroed per edge (idx 1..NREGS-1); writes and
//            scoreboard sets ignored, reads return 0 / not busy.
//     RUN:   writes land on the edge, highest-numbered port wins on an
//            address collision; scoreboard set beats clear on same address.
//
//   Configuration macro:
//     REGFILE_BYPASS_EN  same-cycle write-to-read forwarding of rd_data and
//                        rd_busy (RUN only). Undefined: no forwarding.
// ---------------------------------------------------------------------------
module regfile_multiport #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_multiport_if.slave   bus
);
  localparam int            AW       = $clog2(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t          state;
  logic [AW-1:0]   clr_idx;
  logic [NREGS-1:0] busy;
  logic [XLEN-1:0] regs [NREGS];

  logic [NRD-1:0][XLEN-1:0] rd_data_c;
  logic [NRD-1:0]           rd_busy_c;

  // Control FSM and scoreboard.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_CLEAR;
      clr_idx <= AW'(1);
      busy    <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == LAST_IDX) state <= S_RUN;
        end
        S_RUN: begin
          // Writeback clears first; a later set to the same address
          // overrides it, so an instruction re-issued to the same
          // destination keeps the bit pending.
          for (int p = 0; p < NWR; p++) begin
            if (bus.wr_en[p]) busy[bus.wr_addr[p]] <= 1'b0;
          end
          if (bus.sb_set_en && bus.sb_set_addr != '0)
            busy[bus.sb_set_addr] <= 1'b1;
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  // Storage array.
  // NOTE: the array itself has no reset; the clear engine zeroes it one
  // entry per cycle so it can map onto plain RAM/flop arrays without a
  // wide reset fan-out. Unswept entries are hidden by the CLEAR read gating.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_CLEAR) begin
        regs[clr_idx] <= '0;
      end else begin
        // Ascending port order: the last assignment to an address wins,
        // giving the highest-numbered port priority on a collision.
        for (int p = 0; p < NWR; p++) begin
          if (bus.wr_en[p] && bus.wr_addr[p] != '0)
            regs[bus.wr_addr[p]] <= bus.wr_data[p];
        end
      end
    end
  end

  // Read ports.
  // NOTE: combinational outputs get a default before any conditional
  // assignment so no path leaves them unassigned (no latch inferred).
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    logic fwd_hit;
    fwd_hit = 1'b0;
`endif
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int r = 0; r < NRD; r++) begin
      if (state == S_RUN && bus.rd_addr[r] != '0) begin
        rd_data_c[r] = regs[bus.rd_addr[r]];
        rd_busy_c[r] = busy[bus.rd_addr[r]];
`ifdef REGFILE_BYPASS_EN
        fwd_hit = 1'b0;
        for (int p = 0; p < NWR; p++) begin
          if (bus.wr_en[p] && bus.wr_addr[p] == bus.rd_addr[r]) begin
            rd_data_c[r] = bus.wr_data[p];
            fwd_hit      = 1'b1;
          end
        end
        // A forwarded write will clear the bit unless a same-cycle issue
        // re-marks the register as pending.
        if (fwd_hit && !(bus.sb_set_en && bus.sb_set_addr == bus.rd_addr[r]))
          rd_busy_c[r] = 1'b0;
`endif
      end
    end
  end

  assign bus.rd_data = rd_data_c;
  assign bus.rd_busy = rd_busy_c;
  assign bus.ready   = (state == S_RUN);

endmodule

// File: tb/tb_regfile_multiport.sv
// ---------------------------------------------------------------------------
// tb_regfile_multiport
//   Self-checking bench for regfile_multiport (default parameters).
//   Directed vector table, hand-written reset/bypass sequences and a
//   randomized phase compared against a behavioural model.
// ---------------------------------------------------------------------------
module tb_regfile_multiport;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = $clog2(NREGS);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_multiport_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

  regfile_multiport #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [XLEN-1:0] m_reg  [NREGS];
  bit              m_busy [NREGS];
  bit              m_run = 1'b0;
  int              m_cnt = 0;

  // Advance the model by one rising edge using the inputs currently driven.
  function automatic void model_edge();
    int w;
    bit s;
    if (reset) begin
      m_run = 1'b0;
      m_cnt = 0;
      foreach (m_busy[a]) m_busy[a] = 1'b0;
    end else if (!m_run) begin
      m_cnt++;
      if (m_cnt == NREGS - 1) begin
        m_run = 1'b1;
        foreach (m_reg[a]) m_reg[a] = '0;
      end
    end else begin
      for (int a = 1; a < NREGS; a++) begin
        w = -1;
        for (int p = 0; p < NWR; p++)
          if (bus.wr_en[p] && int'(bus.wr_addr[p]) == a) w = p;
        s = bus.sb_set_en && int'(bus.sb_set_addr) == a;
        if (w >= 0) m_reg[a] = bus.wr_data[w];
        if (s) m_busy[a] = 1'b1;
        else if (w >= 0) m_busy[a] = 1'b0;
      end
    end
  endfunction

  function automatic logic [XLEN-1:0] exp_data(int r);
    int a;
    logic [XLEN-1:0] d;
    a = int'(bus.rd_addr[r]);
    if (!m_run || a == 0) return '0;
    d = m_reg[a];
`ifdef REGFILE_BYPASS_EN
    for (int p = 0; p < NWR; p++)
      if (bus.wr_en[p] && int'(bus.wr_addr[p]) == a) d = bus.wr_data[p];
`endif
    return d;
  endfunction

  function automatic logic exp_busy(int r);
    int a;
    logic b;
    bit hit;
    a = int'(bus.rd_addr[r]);
    if (!m_run || a == 0) return 1'b0;
    b = m_busy[a];
    hit = 1'b0;
`ifdef REGFILE_BYPASS_EN
    for (int p = 0; p < NWR; p++)
      if (bus.wr_en[p] && int'(bus.wr_addr[p]) == a) hit = 1'b1;
    if (hit && !(bus.sb_set_en && int'(bus.sb_set_addr) == a)) b = 1'b0;
`endif
    return b;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    bus.wr_en       = '0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.sb_set_en   = 1'b0;
    bus.sb_set_addr = '0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic read2(input int a0, input int a1);
    bus.rd_addr[0] = AW'(a0);
    bus.rd_addr[1] = AW'(a1);
    #1;
  endtask

  task automatic wait_ready(output int edges);
    edges = 0;
    while (!bus.ready && edges < 200) begin
      tick();
      edges++;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string                    name;
    logic [NWR-1:0]           wr_en;
    logic [NWR-1:0][AW-1:0]   wr_addr;
    logic [NWR-1:0][XLEN-1:0] wr_data;
    logic                     sb_en;
    logic [AW-1:0]            sb_addr;
    int                       rd0, rd1;
    logic [XLEN-1:0]          exp0, exp1;
    logic                     busy0, busy1;
  } vec_t;

  function automatic vec_t mk(string name, logic [1:0] we, int a0, int d0,
                              int a1, int d1, logic sbe, int sba, int r0, int r1,
                              int e0, int e1, logic b0, logic b1);
    vec_t v;
    v.name = name;     v.wr_en = we;
    v.wr_addr[0] = AW'(a0);   v.wr_data[0] = XLEN'(d0);
    v.wr_addr[1] = AW'(a1);   v.wr_data[1] = XLEN'(d1);
    v.sb_en = sbe;     v.sb_addr = AW'(sba);
    v.rd0 = r0;        v.rd1 = r1;
    v.exp0 = XLEN'(e0); v.exp1 = XLEN'(e1);
    v.busy0 = b0;      v.busy1 = b1;
    return v;
  endfunction

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;

    vecs[0] = mk("basic",       2'b11,  5, 123,  6, -7,   1'b0,  0,  5,  6, 123, -7, 1'b0, 1'b0);
    vecs[1] = mk("x0_write",    2'b01,  0,  99, 10,  1,   1'b0,  0,  0,  5,   0, 123, 1'b0, 1'b0);
    vecs[2] = mk("collision",   2'b11,  9,  10,  9, 20,   1'b0,  0,  9,  9,  20, 20, 1'b0, 1'b0);
    vecs[3] = mk("sb_set",      2'b00,  0,   0,  0,  0,   1'b1, 12, 12,  9,   0, 20, 1'b1, 1'b0);
    vecs[4] = mk("sb_set_wr",   2'b10,  0,   0, 12, 77,   1'b1, 12, 12, 12,  77, 77, 1'b1, 1'b1);
    vecs[5] = mk("sb_wr_clear", 2'b01, 12,  78,  0,  0,   1'b0,  0, 12,  6,  78, -7, 1'b0, 1'b0);
    vecs[6] = mk("sb_set_x0",   2'b01,  0,   5,  0,  0,   1'b1,  0,  0,  0,   0,  0, 1'b0, 1'b0);
    vecs[7] = mk("wr_disabled", 2'b00,  5,   1,  9,  2,   1'b0,  0,  5,  9, 123, 20, 1'b0, 1'b0);

    // ---- reset sweep ----
    idle();
    bus.rd_addr = '0;
    reset = 1'b1;
    tick();
    tick();
    read2(5, 6);
    check("reset ready", XLEN'(bus.ready), 0);
    check("reset rd_data0", bus.rd_data[0], 0);
    check("reset rd_data1", bus.rd_data[1], 0);
    check("reset rd_busy", XLEN'(bus.rd_busy), 0);
    reset = 1'b0;
    wait_ready(edges);
    check("sweep edges to ready", XLEN'(edges), XLEN'(NREGS - 1));
    for (int a = 1; a < NREGS; a++) begin
      read2(a, a);
      check($sformatf("swept x%0d port0", a), bus.rd_data[0], 0);
      check($sformatf("swept x%0d port1", a), bus.rd_data[1], 0);
    end

    // ---- directed table ----
    foreach (vecs[i]) begin
      bus.wr_en       = vecs[i].wr_en;
      bus.wr_addr     = vecs[i].wr_addr;
      bus.wr_data     = vecs[i].wr_data;
      bus.sb_set_en   = vecs[i].sb_en;
      bus.sb_set_addr = vecs[i].sb_addr;
      tick();
      idle();
      read2(vecs[i].rd0, vecs[i].rd1);
      check({vecs[i].name, " rd_data0"}, bus.rd_data[0], vecs[i].exp0);
      check({vecs[i].name, " rd_data1"}, bus.rd_data[1], vecs[i].exp1);
      check({vecs[i].name, " rd_busy0"}, XLEN'(bus.rd_busy[0]), XLEN'(vecs[i].busy0));
      check({vecs[i].name, " rd_busy1"}, XLEN'(bus.rd_busy[1]), XLEN'(vecs[i].busy1));
    end

    // ---- same-cycle write/read of x3 (bypass vs. no bypass) ----
    idle();
    bus.sb_set_en = 1'b1;  bus.sb_set_addr = AW'(3);
    tick();
    idle();
    bus.wr_en[0] = 1'b1;  bus.wr_addr[0] = AW'(3);  bus.wr_data[0] = XLEN'(55);
    read2(3, 3);
`ifdef REGFILE_BYPASS_EN
    check("bypass same-cycle data", bus.rd_data[0], 55);
    check("bypass same-cycle busy", XLEN'(bus.rd_busy[1]), 0);
`else
    check("nobypass same-cycle data", bus.rd_data[0], 0);
    check("nobypass same-cycle busy", XLEN'(bus.rd_busy[1]), 1);
`endif
    tick();
    idle();
    read2(3, 3);
    check("x3 next-cycle data", bus.rd_data[1], 55);
    check("x3 next-cycle busy", XLEN'(bus.rd_busy[0]), 0);

    // ---- reset mid-operation ----
    bus.wr_en[0] = 1'b1;  bus.wr_addr[0] = AW'(7);  bus.wr_data[0] = XLEN'(42);
    bus.sb_set_en = 1'b1; bus.sb_set_addr = AW'(8);
    tick();
    idle();
    read2(7, 8);
    check("x7 before reset", bus.rd_data[0], 42);
    check("x8 busy before reset", XLEN'(bus.rd_busy[1]), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    read2(7, 8);
    check("midreset ready", XLEN'(bus.ready), 0);
    check("midreset x7 data", bus.rd_data[0], 0);
    check("midreset busy", XLEN'(bus.rd_busy), 0);
    wait_ready(edges);
    check("midreset sweep edges", XLEN'(edges), XLEN'(NREGS - 1));
    read2(7, 8);
    check("x7 after sweep", bus.rd_data[0], 0);
    check("busy after sweep", XLEN'(bus.rd_busy), 0);

    // ---- randomized phase against the model ----
    for (int cyc = 0; cyc < 600; cyc++) begin
      reset = ($urandom_range(0, 149) == 0);
      for (int p = 0; p < NWR; p++) begin
        bus.wr_en[p]   = $urandom_range(0, 1) == 1;
        bus.wr_addr[p] = AW'($urandom_range(0, ($urandom_range(0, 1) == 1) ? 7 : NREGS - 1));
        bus.wr_data[p] = XLEN'($urandom());
      end
      bus.sb_set_en   = $urandom_range(0, 2) == 0;
      bus.sb_set_addr = AW'($urandom_range(0, 7));
      for (int r = 0; r < NRD; r++)
        bus.rd_addr[r] = AW'($urandom_range(0, 7));
      #1;
      check($sformatf("rand %0d ready", cyc), XLEN'(bus.ready), XLEN'(m_run));
      for (int r = 0; r < NRD; r++) begin
        check($sformatf("rand %0d rd_data%0d a=%0d", cyc, r, bus.rd_addr[r]),
              bus.rd_data[r], exp_data(r));
        check($sformatf("rand %0d rd_busy%0d a=%0d", cyc, r, bus.rd_addr[r]),
              XLEN'(bus.rd_busy[r]), XLEN'(exp_busy(r)));
      end
      tick();
    end

    reset = 1'b0;
    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
